transmisor: RTL and testbench
=============================

TRANSMISOR -- requirements
Module: transmisor

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits, legal range 1..32.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 inserts an even-parity bit, 0 omits it.
REQ-003 SHALL have parameter BIT_CYCLES, default 1: CLK cycles per serial bit, legal range 1..65535.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port tx_data, input, DATA_W bits: parallel word to send.
REQ-007 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-008 SHALL have port tx_ready, output, 1 bit: block can accept a word.
REQ-009 SHALL have port signal_out, output, 1 bit, registered: serial line, idle level 0.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-012 SHALL transmit each frame in this order: start bit = 1; DATA_W data bits, LSB first; parity bit if PARITY_EN = 1; stop bit = 0.
REQ-013 SHALL hold each bit on signal_out for exactly BIT_CYCLES cycles, timed by an internal counter that reloads at every bit boundary.
REQ-014 SHALL have FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL drive tx_ready = 1 only in IDLE and when RST = 0.
REQ-016 SHALL accept a word on a cycle where tx_valid = 1 and tx_ready = 1: tx_data latched into the shift register, parity computed, FSM moves to START.
REQ-017 SHALL make the start bit appear on signal_out on the cycle after acceptance (latency 1 cycle).
REQ-018 SHALL ignore tx_data and tx_valid changes while not in IDLE, with no effect on the frame in flight.
REQ-019 SHALL set the parity bit to the XOR of all latched data bits, so the total count of ones is even.
REQ-020 SHALL sequence the FSM as START -> DATA after BIT_CYCLES; DATA -> PARITY (PARITY_EN = 1) or STOP (PARITY_EN = 0) after DATA_W bits; PARITY -> STOP; STOP -> IDLE.
REQ-021 SHALL shift the shift register right by one at each DATA bit boundary, with the data-bit counter running 0..DATA_W-1.
REQ-022 SHALL make the frame length exactly (2 + DATA_W + PARITY_EN) * BIT_CYCLES cycles of busy = 1.
REQ-023 SHALL pulse done high for exactly one cycle, on the last cycle of the stop bit; that is also the last cycle with busy = 1.
REQ-024 SHALL hold signal_out = 0 in IDLE.
REQ-025 SHALL support back-to-back frames: when tx_valid is held high, the next word is accepted on the first IDLE cycle, giving exactly one idle cycle (signal_out = 0) between the stop bit and the next start bit.
REQ-026 SHALL behave with BIT_CYCLES = 1 exactly as the general case, with one cycle per bit and no extra gap cycles.
REQ-027 SHALL hold all outputs at their IDLE values with no X outputs when tx_valid = 0 in IDLE.

Reset
REQ-028 SHALL, while RST = 1 at a rising CLK edge, set signal_out = 0, busy = 0, done = 0, FSM = IDLE, clear all counters and the shift register, and drive tx_ready = 0.
REQ-029 SHALL, on RST asserted mid-frame, abort the frame: the word is discarded, there is no done pulse, and signal_out = 0 from the next cycle.
REQ-030 SHALL, on the first cycle after RST deasserts, present tx_ready = 1 and accept a word offered on that same cycle.

Verification
REQ-031 SHALL cover, with DATA_W=8, PARITY_EN=1, BIT_CYCLES=1: send 0xA5 -> signal_out = 1,1,0,1,0,0,1,0,1,0,0 over 11 cycles; done on the 11th cycle.
REQ-032 SHALL cover, same parameters: send 0x07 -> parity bit = 1; frame 1,1,1,1,0,0,0,0,0,1,0.
REQ-033 SHALL cover, with BIT_CYCLES=4, PARITY_EN=0: send 0x01 -> start bit high for 4 cycles, then bit0 = 1 for 4 cycles, then 0 for 32 cycles; busy high for 40 cycles.
REQ-034 SHALL cover tx_valid held high with words 0x3C then 0xC3 -> two complete frames separated by exactly one idle cycle at 0, and tx_ready high only on that idle cycle.
REQ-035 SHALL cover RST pulsed for 1 cycle during data bit 3 of 0xFF -> no done pulse, signal_out = 0 and busy = 0 on the next cycle, and a new word accepted on the cycle after RST deasserts.
REQ-036 SHALL cover tx_data changed from 0xA5 to 0x00 during the frame -> the transmitted frame still encodes 0xA5.

Source files
------------

// File: rtl/transmisor.sv
// ---------------------------------------------------------------------------
// transmisor
// Serialises a parallel word into a frame on a single line:
//   start bit (1), DATA_W data bits LSB first, optional even-parity bit,
//   stop bit (0). Each bit is held for BIT_CYCLES clock cycles. The line
//   idles at 0.
//
// Parameters
//   DATA_W      payload width in bits (1..32)
//   PARITY_EN   1 inserts an even-parity bit, 0 omits it
//   BIT_CYCLES  clock cycles per serial bit (1..65535)
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous active-high reset
//   tx_data     word to send, sampled when it is accepted
//   tx_valid    tx_data is valid
//   tx_ready    high when a word can be accepted (IDLE and not in reset)
//   signal_out  registered serial line
//   busy        high for every cycle of a frame
//   done        one-cycle pulse on the last cycle of the stop bit
// ---------------------------------------------------------------------------
module transmisor #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              signal_out,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [15:0]      LAST_CYC = 16'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       cyc;
    logic [15:0]       cyc_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic              parity;
    logic              parity_next;
    logic              line_next;
    logic              bit_end;

    // Last cycle of the current serial bit.
    assign bit_end = (cyc == LAST_CYC);

    // Next-state logic. The line value is computed from the state being
    // entered so that the registered output lines up with the state that
    // owns it: the start bit shows on the cycle right after acceptance.
    always_comb begin
        state_next  = state;
        cyc_next    = cyc;
        idx_next    = idx;
        shift_next  = shift;
        parity_next = parity;
        line_next   = 1'b0;

        if (state != IDLE) begin
            cyc_next = bit_end ? 16'd0 : cyc + 16'd1;
        end

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next  = START;
                    shift_next  = tx_data;
                    parity_next = ^tx_data;
                    idx_next    = '0;
                    cyc_next    = 16'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   line_next = 1'b1;
            DATA:    line_next = shift_next[0];
            PARITY:  line_next = parity_next;
            default: line_next = 1'b0;
        endcase
    end

    // State, counters, shift register and the serial line. Reset aborts
    // any frame in flight and discards the latched word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cyc        <= 16'd0;
            idx        <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            signal_out <= 1'b0;
        end else begin
            state      <= state_next;
            cyc        <= cyc_next;
            idx        <= idx_next;
            shift      <= shift_next;
            parity     <= parity_next;
            signal_out <= line_next;
        end
    end

    assign tx_ready = (state == IDLE) && !RST;
    assign busy     = (state != IDLE);
    assign done     = (state == STOP) && bit_end;

endmodule

// File: tb/tb_transmisor.sv
// ---------------------------------------------------------------------------
// tb_transmisor
// Drives two transmisor instances: dut_a (8 bits, parity, 1 cycle/bit) and
// dut_b (8 bits, no parity, 4 cycles/bit). Expected frames are built from
// the framing rules as a list of line levels, one per clock cycle.
// ---------------------------------------------------------------------------
module tb_transmisor;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] tx_data_a;
    logic [7:0] tx_data_b;
    logic       tx_valid_a;
    logic       tx_valid_b;
    logic       tx_ready_a;
    logic       tx_ready_b;
    logic       signal_out_a;
    logic       signal_out_b;
    logic       busy_a;
    logic       busy_b;
    logic       done_a;
    logic       done_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    transmisor #(.DATA_W(8), .PARITY_EN(1), .BIT_CYCLES(1)) dut_a (
        .CLK(CLK), .RST(RST), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .signal_out(signal_out_a), .busy(busy_a),
        .done(done_a)
    );

    transmisor #(.DATA_W(8), .PARITY_EN(0), .BIT_CYCLES(4)) dut_b (
        .CLK(CLK), .RST(RST), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .signal_out(signal_out_b), .busy(busy_b),
        .done(done_b)
    );

    // Advance to a point 1 time unit after the next rising edge, where
    // outputs are sampled and inputs are changed.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input bit sel, input logic [7:0] data, input logic valid);
        if (sel) begin
            tx_data_b  = data;
            tx_valid_b = valid;
        end else begin
            tx_data_a  = data;
            tx_valid_a = valid;
        end
    endtask

    // Offer a word once the selected DUT is ready, then check every cycle of
    // the frame plus the idle cycle after it. While the frame runs the inputs
    // carry either hold_valid/hold_data or random noise.
    task automatic applyStimulus(input bit sel, input logic [7:0] word,
                                 input bit hold_valid, input logic [7:0] hold_data,
                                 input bit noise);
        int  bc;
        int  waited;
        int  len;
        bit  levels[$];
        bit  expect_q[$];

        bc     = sel ? 4 : 1;
        waited = 0;
        levels.push_back(1'b1);
        for (int i = 0; i < 8; i++) levels.push_back(word[i]);
        if (!sel) levels.push_back(^word);
        levels.push_back(1'b0);
        foreach (levels[j]) begin
            for (int r = 0; r < bc; r++) expect_q.push_back(levels[j]);
        end
        len = expect_q.size();

        while (!(sel ? tx_ready_b : tx_ready_a) && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) begin
            checkOutput("ready_timeout", sel ? tx_ready_b : tx_ready_a, 1);
            return;
        end

        drive(sel, word, 1'b1);
        tick();
        for (int k = 0; k < len; k++) begin
            if (noise) drive(sel, 8'($urandom), 1'($urandom_range(0, 1)));
            else       drive(sel, hold_data, hold_valid);
            checkOutput("frame_line", sel ? signal_out_b : signal_out_a, expect_q[k]);
            checkOutput("frame_busy", sel ? busy_b : busy_a, 1);
            checkOutput("frame_done", sel ? done_b : done_a, (k == len - 1) ? 1 : 0);
            checkOutput("frame_ready", sel ? tx_ready_b : tx_ready_a, 0);
            tick();
        end
        checkOutput("gap_line", sel ? signal_out_b : signal_out_a, 0);
        checkOutput("gap_busy", sel ? busy_b : busy_a, 0);
        checkOutput("gap_done", sel ? done_b : done_a, 0);
        checkOutput("gap_ready", sel ? tx_ready_b : tx_ready_a, 1);
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        repeat (3) tick();

        // Reset values on both instances.
        checkOutput("rst_line_a", signal_out_a, 0);
        checkOutput("rst_busy_a", busy_a, 0);
        checkOutput("rst_done_a", done_a, 0);
        checkOutput("rst_ready_a", tx_ready_a, 0);
        checkOutput("rst_line_b", signal_out_b, 0);
        checkOutput("rst_ready_b", tx_ready_b, 0);
        RST = 1'b0;
        #1;
        checkOutput("post_rst_ready_a", tx_ready_a, 1);
        checkOutput("post_rst_ready_b", tx_ready_b, 1);

        // Idle with tx_valid low: outputs stay at idle values, no X.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle_line", signal_out_a, 0);
            checkOutput("idle_busy", busy_a, 0);
            checkOutput("idle_done", done_a, 0);
            checkOutput("idle_ready", tx_ready_a, 1);
        end

        // 0xA5 with tx_data switched to 0x00 mid-frame, then 0x07 (parity 1).
        applyStimulus(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h07, 1'b0, 8'h00, 1'b0);

        // Four cycles per bit, no parity.
        applyStimulus(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);

        // Back-to-back with tx_valid held high: 0x3C then 0xC3.
        applyStimulus(1'b0, 8'h3C, 1'b1, 8'hC3, 1'b0);
        applyStimulus(1'b0, 8'hC3, 1'b0, 8'h00, 1'b0);

        // Reset pulse during data bit 3 of 0xFF aborts the frame.
        drive(1'b0, 8'hFF, 1'b1);
        tick();
        drive(1'b0, 8'hFF, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            checkOutput("abort_line", signal_out_a, 1);
            checkOutput("abort_done", done_a, 0);
            if (k < 4) tick();
        end
        RST = 1'b1;
        tick();
        checkOutput("abort_rst_line", signal_out_a, 0);
        checkOutput("abort_rst_busy", busy_a, 0);
        checkOutput("abort_rst_done", done_a, 0);
        checkOutput("abort_rst_ready", tx_ready_a, 0);
        RST = 1'b0;
        #1;
        checkOutput("abort_ready_after", tx_ready_a, 1);
        applyStimulus(1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0);

        // Random words with random input noise during each frame.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0, 8'h00, 1'b1);
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
        end

        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
